// File: rtl/cordic_cos_iter_if.sv
// cordic_cos_iter_if
//   Handshake bundle for the iterative CORDIC sine/cosine engine.
//   Angle input side:  in_valid, in_ready, theta_in (Q2.F signed radians)
//   Result output side: out_valid, out_ready, cos_out, sin_out (Q2.F signed)
//   modport master : the requester/consumer that drives angles and accepts results
//   modport slave  : the engine itself
interface cordic_cos_iter_if #(
    parameter int F = 20
) ();
    logic                in_valid;
    logic                in_ready;
    logic signed [F+1:0] theta_in;
    logic                out_valid;
    logic                out_ready;
    logic signed [F+1:0] cos_out;
    logic signed [F+1:0] sin_out;

    modport master (
        output in_valid,
        output theta_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  cos_out,
        input  sin_out
    );

    modport slave (
        input  in_valid,
        input  theta_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output cos_out,
        output sin_out
    );
endinterface

// File: rtl/cordic_cos_iter.sv
// cordic_cos_iter
//   Sequential CORDIC sine/cosine engine: one micro-rotation per clock through a
//   single shift/add stage, ITER+1 rotations per angle. Angles with
//   |theta| > pi/2 are folded back into [-pi/2, pi/2] and the cosine sign is
//   restored at the end. One transaction in flight.
//   Ports:
//     clk  - rising-edge clock
//     rst  - asynchronous, active-high reset
//     bus  - cordic_cos_iter_if.slave (angle in / cos,sin out, valid-ready both sides)
//
//   state | meaning
//   IDLE  | waiting for an angle; in_ready high
//   ROT   | one micro-rotation per edge, i = 0..ITER
//   DONE  | result held on cos_out/sin_out with out_valid high until taken
module cordic_cos_iter #(
    parameter int F    = 20,
    parameter int ITER = 10
) (
    input  logic               clk,
    input  logic               rst,
    cordic_cos_iter_if.slave   bus
);
    localparam int W  = F + 3;
    localparam int OW = F + 2;
    localparam int CW = $clog2(ITER + 1);

    // Reciprocal of the CORDIC gain, so the rotated vector lands at unit length.
    function automatic int gain_inv();
        real p;
        p = 1.0;
        for (int i = 0; i <= ITER; i++) begin
            p = p * $sqrt(1.0 + 1.0 / (4.0 ** i));
        end
        return $rtoi((2.0 ** F) / p);
    endfunction

    localparam logic signed [W-1:0] K_C    = W'(gain_inv());
    localparam logic signed [W-1:0] PI_H_C = W'($rtoi(3.141592653589793 / 2.0 * (2.0 ** F)));
    localparam logic signed [W-1:0] PI_C   = W'($rtoi(3.141592653589793 * (2.0 ** F)));
    localparam logic [CW-1:0]       LAST_I = CW'(ITER);

    logic signed [W-1:0] atan_lut [ITER+1];

    for (genvar g = 0; g <= ITER; g++) begin : g_atan
        localparam int ATAN_G = $rtoi($atan(1.0 / (2.0 ** g)) * (2.0 ** F));
        assign atan_lut[g] = W'(ATAN_G);
    end

    typedef enum logic [1:0] {IDLE, ROT, DONE} state_t;

    state_t               state_q, state_d;
    logic signed [W-1:0]  x_q, x_d;
    logic signed [W-1:0]  y_q, y_d;
    logic signed [W-1:0]  z_q, z_d;
    logic [CW-1:0]        i_q, i_d;
    logic                 neg_q, neg_d;
    logic signed [OW-1:0] cos_q, cos_d;
    logic signed [OW-1:0] sin_q, sin_d;

    logic signed [W-1:0]  theta_ext;
    logic signed [W-1:0]  xs, ys;
    logic signed [W-1:0]  x_n, y_n, z_n;
    logic                 d_pos;

    assign theta_ext = {bus.theta_in[OW-1], bus.theta_in};

    // Single shared micro-rotation stage; all terms use the pre-edge x/y/z.
    assign d_pos = !z_q[W-1];
    assign xs    = x_q >>> i_q;
    assign ys    = y_q >>> i_q;
    assign x_n   = d_pos ? (x_q - ys) : (x_q + ys);
    assign y_n   = d_pos ? (y_q + xs) : (y_q - xs);
    assign z_n   = d_pos ? (z_q - atan_lut[i_q]) : (z_q + atan_lut[i_q]);

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        i_d     = i_q;
        neg_d   = neg_q;
        cos_d   = cos_q;
        sin_d   = sin_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d = ROT;
                    x_d     = K_C;
                    y_d     = '0;
                    i_d     = '0;
                    // Exactly +/-pi/2 stays unfolded; the rotation range covers it.
                    if (theta_ext > PI_H_C) begin
                        z_d   = PI_C - theta_ext;
                        neg_d = 1'b1;
                    end else if (theta_ext < -PI_H_C) begin
                        z_d   = -PI_C - theta_ext;
                        neg_d = 1'b1;
                    end else begin
                        z_d   = theta_ext;
                        neg_d = 1'b0;
                    end
                end
            end
            ROT: begin
                x_d = x_n;
                y_d = y_n;
                z_d = z_n;
                if (i_q == LAST_I) begin
                    state_d = DONE;
                    // Folding mirrors the angle about pi/2: sine is unchanged, cosine flips.
                    cos_d   = neg_q ? OW'(-x_n) : OW'(x_n);
                    sin_d   = OW'(y_n);
                end else begin
                    i_d = i_q + CW'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            i_q     <= '0;
            neg_q   <= 1'b0;
            cos_q   <= '0;
            sin_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            i_q     <= i_d;
            neg_q   <= neg_d;
            cos_q   <= cos_d;
            sin_q   <= sin_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign bus.out_valid = (state_q == DONE);
    assign bus.cos_out   = cos_q;
    assign bus.sin_out   = sin_q;
endmodule

// File: tb/tb_cordic_cos_iter.sv
module tb_cordic_cos_iter;
    localparam int F   = 20;
    localparam int TOL = 2048;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    cordic_cos_iter_if #(.F(F)) bus ();

    cordic_cos_iter #(.F(F), .ITER(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running, need finished");
        $fatal(1);
    end

    function automatic int q(input real r);
        return $rtoi(r * 1048576.0);
    endfunction

    function automatic int adiff(input int a, input int b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    // Stimulus only: present an angle, wait for acceptance and the result (left unconsumed).
    task automatic txn(input int th, output int lat, output int c, output int s, output bit rdy_seen);
        int n;
        bus.in_valid = 1'b1;
        bus.theta_in = (F+2)'(th);
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        rdy_seen = bus.in_ready;
        lat = -1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            if (bus.out_valid) begin
                lat = k;
                break;
            end
            if (bus.in_ready) rdy_seen = 1'b1;
        end
        c = int'(bus.cos_out);
        s = int'(bus.sin_out);
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.theta_in  = '0;
        #2;
        vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready got %b need 0", bus.in_ready); end
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b need 0", bus.out_valid); end
        vectors++; if (bus.cos_out !== '0) begin miscompares++; $display("FAIL reset_cos got %0d need 0", bus.cos_out); end
        vectors++; if (bus.sin_out !== '0) begin miscompares++; $display("FAIL reset_sin got %0d need 0", bus.sin_out); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL release_in_ready got %b need 1", bus.in_ready); end
    endtask

    task automatic test_basic();
        int lat, c, s;
        bit rdy;
        txn(q(0.785), lat, c, s, rdy);
        vectors++; if (lat !== 11) begin miscompares++; $display("FAIL basic_latency got %0d need 11", lat); end
        vectors++; if (rdy !== 1'b0) begin miscompares++; $display("FAIL basic_busy_in_ready got %b need 0", rdy); end
        vectors++; if (adiff(c, q(0.70739)) > TOL) begin miscompares++; $display("FAIL basic_cos got %0d need %0d +/- %0d", c, q(0.70739), TOL); end
        vectors++; if (adiff(s, q(0.70683)) > TOL) begin miscompares++; $display("FAIL basic_sin got %0d need %0d +/- %0d", s, q(0.70683), TOL); end
        vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL basic_done_in_ready got %b need 0", bus.in_ready); end
        consume();
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_out_valid_drop got %b need 0", bus.out_valid); end
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL basic_back_idle got %b need 1", bus.in_ready); end
    endtask

    task automatic test_zero();
        int lat, c, s;
        bit rdy;
        txn(0, lat, c, s, rdy);
        vectors++; if (adiff(c, 1048576) > TOL) begin miscompares++; $display("FAIL zero_cos got %0d need 1048576 +/- %0d", c, TOL); end
        vectors++; if (adiff(s, 0) > TOL) begin miscompares++; $display("FAIL zero_sin got %0d need 0 +/- %0d", s, TOL); end
        consume();
    endtask

    task automatic test_fold();
        int lat, c, s;
        bit rdy;
        txn(q(1.9), lat, c, s, rdy);
        vectors++; if (adiff(c, q(-0.32329)) > TOL) begin miscompares++; $display("FAIL fold_pos_cos got %0d need %0d", c, q(-0.32329)); end
        vectors++; if (adiff(s, q(0.94630)) > TOL) begin miscompares++; $display("FAIL fold_pos_sin got %0d need %0d", s, q(0.94630)); end
        consume();
        txn(-q(1.9), lat, c, s, rdy);
        vectors++; if (adiff(c, q(-0.32329)) > TOL) begin miscompares++; $display("FAIL fold_neg_cos got %0d need %0d", c, q(-0.32329)); end
        vectors++; if (adiff(s, q(-0.94630)) > TOL) begin miscompares++; $display("FAIL fold_neg_sin got %0d need %0d", s, q(-0.94630)); end
        consume();
    endtask

    task automatic test_half_pi();
        int lat, c, s;
        bit rdy;
        int pi_h;
        pi_h = $rtoi(3.141592653589793 / 2.0 * 1048576.0);
        txn(pi_h, lat, c, s, rdy);
        vectors++; if (adiff(c, 0) > TOL) begin miscompares++; $display("FAIL pih_pos_cos got %0d need 0 +/- %0d", c, TOL); end
        vectors++; if (adiff(s, 1048576) > TOL) begin miscompares++; $display("FAIL pih_pos_sin got %0d need 1048576", s); end
        consume();
        txn(-pi_h, lat, c, s, rdy);
        vectors++; if (adiff(c, 0) > TOL) begin miscompares++; $display("FAIL pih_neg_cos got %0d need 0 +/- %0d", c, TOL); end
        vectors++; if (adiff(s, -1048576) > TOL) begin miscompares++; $display("FAIL pih_neg_sin got %0d need -1048576", s); end
        consume();
    endtask

    task automatic test_stall();
        int lat, c, s, lat2;
        bit rdy;
        txn(q(1.2), lat, c, s, rdy);
        bus.in_valid = 1'b1;
        bus.theta_in = (F+2)'(-q(0.785));
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL stall_out_valid cyc %0d got %b need 1", k, bus.out_valid); end
            vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL stall_in_ready cyc %0d got %b need 0", k, bus.in_ready); end
            vectors++; if (int'(bus.cos_out) !== c || int'(bus.sin_out) !== s) begin miscompares++; $display("FAIL stall_hold cyc %0d got %0d/%0d need %0d/%0d", k, bus.cos_out, bus.sin_out, c, s); end
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        vectors++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL stall_release got v%b r%b need v0 r1", bus.out_valid, bus.in_ready); end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL stall_accept got in_ready %b need 0", bus.in_ready); end
        lat2 = -1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            if (bus.out_valid) begin lat2 = k; break; end
        end
        vectors++; if (lat2 !== 11) begin miscompares++; $display("FAIL stall_next_latency got %0d need 11", lat2); end
        vectors++; if (adiff(int'(bus.cos_out), q(0.70739)) > TOL) begin miscompares++; $display("FAIL stall_next_cos got %0d need %0d", bus.cos_out, q(0.70739)); end
        vectors++; if (adiff(int'(bus.sin_out), q(-0.70683)) > TOL) begin miscompares++; $display("FAIL stall_next_sin got %0d need %0d", bus.sin_out, q(-0.70683)); end
        consume();
    endtask

    task automatic test_reset_mid_rot();
        int lat, c, s, pulses;
        bit rdy;
        bus.in_valid = 1'b1;
        bus.theta_in = (F+2)'(q(1.0));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_out_valid got %b need 0", bus.out_valid); end
        vectors++; if (bus.cos_out !== '0 || bus.sin_out !== '0) begin miscompares++; $display("FAIL midrst_outputs got %0d/%0d need 0/0", bus.cos_out, bus.sin_out); end
        vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL midrst_in_ready got %b need 0", bus.in_ready); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        pulses = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            if (bus.out_valid) pulses++;
        end
        vectors++; if (pulses !== 0) begin miscompares++; $display("FAIL midrst_ghost_valid got %0d cycles need 0", pulses); end
        txn(q(0.5), lat, c, s, rdy);
        vectors++; if (lat !== 11) begin miscompares++; $display("FAIL midrst_latency got %0d need 11", lat); end
        vectors++; if (adiff(c, q(0.87758)) > TOL) begin miscompares++; $display("FAIL midrst_cos got %0d need %0d", c, q(0.87758)); end
        vectors++; if (adiff(s, q(0.47943)) > TOL) begin miscompares++; $display("FAIL midrst_sin got %0d need %0d", s, q(0.47943)); end
        consume();
    endtask

    task automatic test_back_to_back();
        int acc1, acc2, ov_cycles, cval, sval;
        bit rdy_before;
        acc1 = -1; acc2 = -1; ov_cycles = 0; cval = 0; sval = 0;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.theta_in  = (F+2)'(q(0.3));
        for (int cyc = 0; cyc < 60 && acc2 < 0; cyc++) begin
            rdy_before = bus.in_ready;
            @(posedge clk); #1;
            if (rdy_before) begin
                if (acc1 < 0) acc1 = cyc; else acc2 = cyc;
            end
            if (bus.out_valid && acc1 >= 0 && acc2 < 0) begin
                ov_cycles++;
                cval = int'(bus.cos_out);
                sval = int'(bus.sin_out);
            end
        end
        bus.in_valid = 1'b0;
        vectors++; if (acc2 - acc1 !== 13 || acc1 < 0) begin miscompares++; $display("FAIL b2b_spacing got %0d need 13", acc2 - acc1); end
        vectors++; if (ov_cycles !== 1) begin miscompares++; $display("FAIL b2b_valid_len got %0d need 1", ov_cycles); end
        vectors++; if (adiff(cval, q(0.95534)) > TOL || adiff(sval, q(0.29552)) > TOL) begin miscompares++; $display("FAIL b2b_result got %0d/%0d need %0d/%0d", cval, sval, q(0.95534), q(0.29552)); end
        for (int k = 0; k < 30 && !bus.in_ready; k++) begin
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_basic();
        test_zero();
        test_fold();
        test_half_pi();
        test_stall();
        test_reset_mid_rot();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
